// File: rtl/dbg_pkg.sv
// dbg_pkg: shared debug-block types: dump FSM states and byte-stream widths.
package dbg_pkg;
   localparam int BYTE_W = 8;
   typedef logic [BYTE_W-1:0] byte_t;
   typedef enum logic [2:0] {IDLE, HALT_WAIT, ADDR, CAPTURE, SEND, NEXT, DONE} dump_state_t;
endpackage

// File: rtl/reg_dump_controller_if.sv
// reg_dump_controller_if: halt handshake, register read port and byte-stream bundle.
interface reg_dump_controller_if #(
   parameter int SIZE         = 32,
   parameter int SIZE_REG_DIR = 5
);
   import dbg_pkg::*;
   logic i_dump_start;
   logic i_pipe_halted;
   logic o_halt_req;
   logic [SIZE_REG_DIR-1:0] o_rd_dir;
   logic [SIZE-1:0] i_rd_data;
   byte_t o_tx_data;
   logic o_tx_valid;
   logic i_tx_ready;
   logic o_busy;
   logic o_done;
   modport master (
      input  i_dump_start, i_pipe_halted, i_rd_data, i_tx_ready,
      output o_halt_req, o_rd_dir, o_tx_data, o_tx_valid, o_busy, o_done
   );
   modport slave (
      output i_dump_start, i_pipe_halted, i_rd_data, i_tx_ready,
      input  o_halt_req, o_rd_dir, o_tx_data, o_tx_valid, o_busy, o_done
   );
endinterface

// File: rtl/reg_dump_controller_word_serializer.sv
// word_serializer: emits a loaded word LSB byte first on a registered ready/valid stream.
module word_serializer
   import dbg_pkg::*;
#(
   parameter int SIZE           = 32,
   parameter int BYTES_PER_WORD = SIZE / BYTE_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [SIZE-1:0] word,
   input  logic            ready,
   output byte_t           data,
   output logic            valid,
   output logic            last
);
   localparam int CW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
   logic [SIZE-1:0] shreg;
   logic [CW-1:0] bcnt;
   assign data = shreg[BYTE_W-1:0];
   assign last = valid && ready && bcnt == CW'(BYTES_PER_WORD - 1);
   always_ff @(posedge clk)
      if (rst) begin
         shreg <= '0;
         bcnt  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         shreg <= word;
         bcnt  <= '0;
         valid <= 1'b1;
      end else if (valid && ready) begin
         shreg <= shreg >> BYTE_W;
         bcnt  <= bcnt + 1'b1;
         valid <= !last;
      end
endmodule

// File: rtl/reg_dump_controller.sv
// reg_dump_controller: halts the pipeline and streams every register out LSB byte first.
module reg_dump_controller
   import dbg_pkg::*;
#(
   parameter int SIZE           = 32,
   parameter int NUM_REGISTERS  = 32,
   parameter int SIZE_REG_DIR   = $clog2(NUM_REGISTERS),
   parameter int BYTES_PER_WORD = SIZE / BYTE_W
) (
   input logic clk,
   input logic rst,
   reg_dump_controller_if.master bus
);
   dump_state_t state, state_next;
   logic [SIZE_REG_DIR-1:0] idx;
   logic active, done, last, tx_valid;
   byte_t tx_data;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      state_next = bus.i_dump_start ? HALT_WAIT : IDLE;
         HALT_WAIT: state_next = bus.i_pipe_halted ? ADDR : HALT_WAIT;
         ADDR:      state_next = CAPTURE;
         CAPTURE:   state_next = SEND;
         SEND:      state_next = last ? NEXT : SEND;
         NEXT:      state_next = idx == SIZE_REG_DIR'(NUM_REGISTERS - 1) ? DONE : ADDR;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end
   // idx doubles as the read address, so it is cleared on the way back to IDLE
   always_ff @(posedge clk)
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         active <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         idx    <= state_next == IDLE ? '0 : (state == NEXT && state_next == ADDR) ? idx + 1'b1 : idx;
         active <= state_next != IDLE;
         done   <= state_next == DONE;
      end
   word_serializer #(.SIZE(SIZE), .BYTES_PER_WORD(BYTES_PER_WORD)) u_ser (
      .clk(clk),
      .rst(rst),
      .load(state == CAPTURE),
      .word(bus.i_rd_data),
      .ready(bus.i_tx_ready),
      .data(tx_data),
      .valid(tx_valid),
      .last(last)
   );
   assign bus.o_halt_req = active;
   assign bus.o_busy     = active;
   assign bus.o_done     = done;
   assign bus.o_rd_dir   = idx;
   assign bus.o_tx_data  = tx_data;
   assign bus.o_tx_valid = tx_valid;
endmodule

// File: doc/reg_dump_controller.md
Name: reg_dump_controller

Overview:
- Debug sequencer that dumps the full register bank contents over a byte-wide ready/valid stream (feeds the UART TX of the debug unit).
- On request it halts the pipeline and waits for the halt acknowledge.
- It then walks every register address on a dedicated read port and serializes each word LSB-byte first.
- When the last byte is sent it releases the halt.

Parameters:
- SIZE, 32, register width in bits; must be a multiple of 8.
- NUM_REGISTERS, 32, number of registers dumped.
- SIZE_REG_DIR, $clog2(NUM_REGISTERS), register address width.
- BYTES_PER_WORD, SIZE/8, bytes emitted per register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_dump_start  in  1  request a full dump; sampled only in IDLE.
- i_pipe_halted  in  1  pipeline acknowledges halt (no register writes in flight).
- o_halt_req  out  1  pipeline halt request.
- o_rd_dir  out  SIZE_REG_DIR  register read address, muxed onto a register bank read port.
- i_rd_data  in  SIZE  register read data.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  sink accepts the byte this cycle.
- o_busy  out  1  dump in progress (any state other than IDLE).
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: state IDLE; all outputs 0 (o_halt_req, o_rd_dir, o_tx_data, o_tx_valid, o_busy, o_done); index, byte count and shift register cleared.
- Reset mid-dump: abort immediately, return to IDLE, drop o_halt_req the cycle after rst is sampled; no partial byte is held valid.
- Register bank read timing: the bank latches on negedge clk, so i_rd_data is valid at the first posedge after o_rd_dir changes.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: when i_dump_start=1, go to HALT_WAIT; set o_halt_req=1, o_busy=1, idx=0.
  - HALT_WAIT: hold until i_pipe_halted=1, then go to ADDR. No timeout.
  - ADDR (1 cycle): o_rd_dir=idx; go to CAPTURE.
  - CAPTURE (1 cycle): shift register <= i_rd_data; bcnt=0; go to SEND.
  - SEND:
    - o_tx_valid=1, o_tx_data = shift register[7:0].
    - On a cycle with o_tx_valid && i_tx_ready: shift right 8 and increment bcnt.
    - If the accepted byte was number BYTES_PER_WORD-1, go to NEXT with o_tx_valid=0 in the following cycle.
  - NEXT: if idx==NUM_REGISTERS-1, go to DONE; else idx++ and go to ADDR.
  - DONE: o_done=1 for one cycle; o_halt_req=0, o_busy=0 from the next cycle; go to IDLE.
- Handshake rules:
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid hold stable.
  - o_tx_valid never depends combinationally on i_tx_ready.
- Dump contents and cost:
  - Exactly NUM_REGISTERS*BYTES_PER_WORD bytes per dump, register 0 first, little-endian within each word.
  - Minimum cycles per register = 3 + BYTES_PER_WORD (ADDR, CAPTURE, bytes, NEXT) with i_tx_ready tied high.
- Boundary conditions:
  - o_rd_dir holds idx from ADDR through NEXT and returns to 0 in IDLE.
  - idx increments only in NEXT; it never wraps past NUM_REGISTERS-1.
  - i_dump_start while busy is ignored; no queuing.
  - i_dump_start and rst asserted in the same cycle: rst wins.
  - i_pipe_halted falling mid-dump is ignored; the halt stays requested, and re-halting is the pipeline's contract.

Decomposition:
- Shared package dbg_pkg:
  - FSM state localparams: IDLE, HALT_WAIT, ADDR, CAPTURE, SEND, NEXT, DONE.
  - BYTE_W=8.
  - Debug byte-stream handshake field widths, shared with the UART TX and other debug blocks.
- Sub-module word_serializer: loads a SIZE-bit word and emits BYTES_PER_WORD bytes LSB first on ready/valid, with a last-byte flag. reg_dump_controller holds the FSM, index counter and halt handshake.

Test Plan:
- Model registers with r0=3, r1=1, r2..r31=3; tie i_pipe_halted=1 and i_tx_ready=1; pulse i_dump_start. Expect 128 bytes: 03 00 00 00, 01 00 00 00, then 03 00 00 00 x30. o_done pulses once. Elapsed cycles = 1 + 1 + 32*7 + 1.
- i_pipe_halted held 0 for 10 cycles after start: o_halt_req=1, o_rd_dir=0 and o_tx_valid=0 throughout; dump starts on the cycle after i_pipe_halted rises.
- i_tx_ready toggles 1,0,0,1 with r5=0xDEADBEEF: bytes EF BE AD DE for r5; o_tx_data stable while stalled; no byte is lost or duplicated.
- Assert rst while sending byte 2 of r7: next cycle all outputs are 0 and state is IDLE. A fresh i_dump_start restarts from r0.
- Pulse i_dump_start again mid-dump and in the DONE cycle: byte count stays 128 and o_done pulses once.
- NUM_REGISTERS=8, SIZE=16 instance: 16 bytes emitted; idx stops at 7; o_rd_dir returns to 0 after DONE.
